// File: rtl/tick_pwm_gen.sv
// tick_pwm_gen: PWM generator timed by a divider's single-cycle tick pulse.
// Period and duty arrive through a valid/ready port and are staged in a shadow
// register. They take effect only on a period boundary, so the output never
// shows a truncated or stretched cycle.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | stopped; counter parked at 0; a pending config loads at once
//   ST_RUN   | enable high; counting ticks and driving the waveform
//   ST_DRAIN | enable dropped; finishing the current period, then stopping
module tick_pwm_gen #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         tick_in,
    input  logic         enable,
    input  logic         cfg_valid,
    input  logic [W-1:0] cfg_period,
    input  logic [W-1:0] cfg_duty,
    output logic         cfg_ready,
    output logic         pwm_out,
    output logic         period_done,
    output logic         busy
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    logic [1:0]   r_state;
    logic [W-1:0] r_cnt;
    logic [W-1:0] r_period_act;
    logic [W-1:0] r_duty_act;
    logic [W-1:0] r_shadow_period;
    logic [W-1:0] r_shadow_duty;
    logic         r_pending;
    logic         r_pwm;
    logic         r_period_done;

    logic         w_cfg_accept;
    logic         w_at_end;
    logic         w_wrap;
    logic         w_load;
    logic [W-1:0] w_cnt_step;
    logic [1:0]   w_state_next;
    logic [W-1:0] w_cnt_next;
    logic [W-1:0] w_period_next;
    logic [W-1:0] w_duty_next;
    logic         w_pwm_next;

    assign cfg_ready   = !r_pending;
    assign busy        = (r_state != ST_IDLE);
    assign pwm_out     = r_pwm;
    assign period_done = r_period_done;

    // Wrap detection, shadow load decision and the counter's tick-advanced value.
    always_comb begin
        w_cfg_accept = cfg_valid && !r_pending;
        w_at_end     = (r_cnt == r_period_act);
        w_wrap       = (r_state != ST_IDLE) && tick_in && w_at_end;
        // In IDLE there is no waveform to protect, so a pending config loads immediately.
        w_load       = r_pending && ((r_state == ST_IDLE) || w_wrap);
        if (!tick_in) begin
            w_cnt_step = r_cnt;
        end else if (w_at_end) begin
            w_cnt_step = '0;
        end else begin
            w_cnt_step = r_cnt + W'(1);
        end
        w_period_next = w_load ? r_shadow_period : r_period_act;
        w_duty_next   = w_load ? r_shadow_duty   : r_duty_act;
    end

    // Next-state and next-count selection for the run/drain sequencer.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                // A tick coinciding with the start request is deliberately dropped.
                w_cnt_next = '0;
                if (enable) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_cnt_next = w_cnt_step;
                if (!enable) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_cnt_next = w_cnt_step;
                if (enable) begin
                    w_state_next = ST_RUN;
                end else if (w_wrap) begin
                    w_state_next = ST_IDLE;
                    w_cnt_next   = '0;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Output level is computed from the post-update count so it lines up with r_cnt.
    always_comb begin
        w_pwm_next = (w_state_next != ST_IDLE) && (w_cnt_next < w_duty_next);
    end

    // Sequencer, counter and active settings.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_period_act <= '0;
            r_duty_act   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_cnt        <= w_cnt_next;
            r_period_act <= w_period_next;
            r_duty_act   <= w_duty_next;
        end
    end

    // Shadow capture; a new offer is refused until the previous one has loaded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow_period <= '0;
            r_shadow_duty   <= '0;
            r_pending       <= 1'b0;
        end else begin
            if (w_cfg_accept) begin
                r_shadow_period <= cfg_period;
                r_shadow_duty   <= cfg_duty;
                r_pending       <= 1'b1;
            end else if (w_load) begin
                r_pending       <= 1'b0;
            end
        end
    end

    // Registered outputs: waveform level and the end-of-period strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pwm         <= 1'b0;
            r_period_done <= 1'b0;
        end else begin
            r_pwm         <= w_pwm_next;
            r_period_done <= w_wrap;
        end
    end

endmodule

// File: tb/tb_tick_pwm_gen.sv
// Directed testbench for tick_pwm_gen with hand-computed expected waveforms.
module tb_tick_pwm_gen;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         tick_in;
    logic         enable;
    logic         cfg_valid;
    logic [W-1:0] cfg_period;
    logic [W-1:0] cfg_duty;
    logic         cfg_ready;
    logic         pwm_out;
    logic         period_done;
    logic         busy;

    int checks;
    int failures;
    int phase;
    int tick_div;
    bit tick_en;

    tick_pwm_gen #(.W(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .tick_in     (tick_in),
        .enable      (enable),
        .cfg_valid   (cfg_valid),
        .cfg_period  (cfg_period),
        .cfg_duty    (cfg_duty),
        .cfg_ready   (cfg_ready),
        .pwm_out     (pwm_out),
        .period_done (period_done),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock: drive tick for this cycle, take the edge, settle 1 time unit past it.
    task automatic step();
        tick_in = tick_en && ((phase % tick_div) == 0);
        phase++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        enable    = 1'b0;
        cfg_valid = 1'b0;
        tick_en   = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Load a config while idle, then raise enable with the tick phase aligned to E0.
    task automatic start_run(input logic [W-1:0] p, input logic [W-1:0] d, input int div);
        cfg_period = p;
        cfg_duty   = d;
        cfg_valid  = 1'b1;
        step();
        cfg_valid  = 1'b0;
        step();
        phase    = 0;
        tick_div = div;
        tick_en  = 1'b1;
        enable   = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pwm_out !== 1'b0 || period_done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state got pwm=%b pd=%b busy=%b rdy=%b exp 0 0 0 1",
                     pwm_out, period_done, busy, cfg_ready);
        end
        tick_div = 1;
        tick_en  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++;
            if (pwm_out !== 1'b0 || period_done !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1) begin
                failures++;
                $display("FAIL idle_tick cyc=%0d got pwm=%b pd=%b busy=%b rdy=%b exp 0 0 0 1",
                         i, pwm_out, period_done, busy, cfg_ready);
            end
        end
        tick_en = 1'b0;
    endtask

    task automatic test_basic();
        logic exp_pwm;
        logic exp_pd;
        do_reset();
        cfg_period = 8'd3;
        cfg_duty   = 8'd1;
        cfg_valid  = 1'b1;
        step();
        checks++;
        if (cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_cfg_pending got rdy=%b exp 0", cfg_ready);
        end
        cfg_valid = 1'b0;
        step();
        checks++;
        if (cfg_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_cfg_applied got rdy=%b busy=%b exp 1 0", cfg_ready, busy);
        end
        phase    = 0;
        tick_div = 4;
        tick_en  = 1'b1;
        enable   = 1'b1;
        for (int i = 0; i < 48; i++) begin
            step();
            exp_pwm = ((i % 16) < 4);
            exp_pd  = (i > 0) && ((i % 16) == 0);
            checks++;
            if (pwm_out !== exp_pwm || period_done !== exp_pd || busy !== 1'b1) begin
                failures++;
                $display("FAIL basic_pwm cyc=%0d got pwm=%b pd=%b busy=%b exp %b %b 1",
                         i, pwm_out, period_done, busy, exp_pwm, exp_pd);
            end
        end
    endtask

    task automatic test_shadow_update();
        logic exp_pwm;
        logic exp_pd;
        logic exp_rdy;
        do_reset();
        start_run(8'd3, 8'd1, 4);
        for (int i = 0; i <= 48; i++) begin
            if (i == 8) begin
                cfg_valid  = 1'b1;
                cfg_period = 8'd7;
                cfg_duty   = 8'd6;
            end else if (i >= 10 && i <= 12) begin
                cfg_valid  = 1'b1;
                cfg_period = 8'd0;
                cfg_duty   = 8'd0;
            end else begin
                cfg_valid  = 1'b0;
            end
            step();
            exp_pwm = (i < 16) ? (i < 4) : (((i - 16) % 32) < 24);
            exp_pd  = (i == 16) || (i == 48);
            exp_rdy = !(i >= 8 && i < 16);
            checks++;
            if (pwm_out !== exp_pwm || period_done !== exp_pd || cfg_ready !== exp_rdy) begin
                failures++;
                $display("FAIL shadow_update cyc=%0d got pwm=%b pd=%b rdy=%b exp %b %b %b",
                         i, pwm_out, period_done, cfg_ready, exp_pwm, exp_pd, exp_rdy);
            end
        end
        cfg_valid = 1'b0;
    endtask

    task automatic test_edge_duties();
        logic exp_pd;
        do_reset();
        start_run(8'd3, 8'd0, 1);
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (pwm_out !== 1'b0 || busy !== 1'b1) begin
                failures++;
                $display("FAIL duty_zero cyc=%0d got pwm=%b busy=%b exp 0 1", i, pwm_out, busy);
            end
        end
        do_reset();
        start_run(8'd2, 8'd5, 1);
        for (int i = 0; i < 12; i++) begin
            step();
            checks++;
            if (pwm_out !== 1'b1 || busy !== 1'b1) begin
                failures++;
                $display("FAIL duty_over_period cyc=%0d got pwm=%b busy=%b exp 1 1", i, pwm_out, busy);
            end
        end
        do_reset();
        start_run(8'd0, 8'd1, 2);
        for (int i = 0; i < 12; i++) begin
            step();
            exp_pd = (i > 0) && ((i % 2) == 0);
            checks++;
            if (pwm_out !== 1'b1 || period_done !== exp_pd) begin
                failures++;
                $display("FAIL period_zero cyc=%0d got pwm=%b pd=%b exp 1 %b",
                         i, pwm_out, period_done, exp_pd);
            end
        end
    endtask

    task automatic test_drain();
        logic exp_pwm;
        logic exp_pd;
        logic exp_busy;
        do_reset();
        start_run(8'd3, 8'd1, 4);
        for (int i = 0; i <= 20; i++) begin
            if (i == 5) enable = 1'b0;
            step();
            exp_busy = (i < 16);
            exp_pwm  = (i < 4);
            exp_pd   = (i == 16);
            checks++;
            if (pwm_out !== exp_pwm || period_done !== exp_pd || busy !== exp_busy) begin
                failures++;
                $display("FAIL drain cyc=%0d got pwm=%b pd=%b busy=%b exp %b %b %b",
                         i, pwm_out, period_done, busy, exp_pwm, exp_pd, exp_busy);
            end
        end
    endtask

    task automatic test_reenable();
        logic exp_pwm;
        logic exp_pd;
        do_reset();
        start_run(8'd3, 8'd1, 4);
        for (int i = 0; i <= 40; i++) begin
            if (i == 5)  enable = 1'b0;
            if (i == 10) enable = 1'b1;
            step();
            exp_pwm = ((i % 16) < 4);
            exp_pd  = (i > 0) && ((i % 16) == 0);
            checks++;
            if (pwm_out !== exp_pwm || period_done !== exp_pd || busy !== 1'b1) begin
                failures++;
                $display("FAIL reenable cyc=%0d got pwm=%b pd=%b busy=%b exp %b %b 1",
                         i, pwm_out, period_done, busy, exp_pwm, exp_pd);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        logic exp_pd;
        do_reset();
        start_run(8'd3, 8'd1, 4);
        step();
        cfg_valid  = 1'b1;
        cfg_period = 8'd7;
        cfg_duty   = 8'd6;
        step();
        checks++;
        if (pwm_out !== 1'b1 || cfg_ready !== 1'b0) begin
            failures++;
            $display("FAIL midrst_before got pwm=%b rdy=%b exp 1 0", pwm_out, cfg_ready);
        end
        cfg_valid = 1'b0;
        rst       = 1'b1;
        tick_en   = 1'b0;
        step();
        checks++;
        if (pwm_out !== 1'b0 || busy !== 1'b0 || cfg_ready !== 1'b1 || period_done !== 1'b0) begin
            failures++;
            $display("FAIL midrst_after got pwm=%b busy=%b rdy=%b pd=%b exp 0 0 1 0",
                     pwm_out, busy, cfg_ready, period_done);
        end
        rst      = 1'b0;
        phase    = 0;
        tick_div = 2;
        tick_en  = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            exp_pd = (i > 0) && ((i % 2) == 0);
            checks++;
            if (pwm_out !== 1'b0 || busy !== 1'b1 || period_done !== exp_pd) begin
                failures++;
                $display("FAIL midrst_discard cyc=%0d got pwm=%b busy=%b pd=%b exp 0 1 %b",
                         i, pwm_out, busy, period_done, exp_pd);
            end
        end
        enable = 1'b0;
    endtask

    initial begin
        checks     = 0;
        failures   = 0;
        phase      = 0;
        tick_div   = 1;
        tick_en    = 1'b0;
        rst        = 1'b1;
        tick_in    = 1'b0;
        enable     = 1'b0;
        cfg_valid  = 1'b0;
        cfg_period = '0;
        cfg_duty   = '0;
        test_reset();
        test_basic();
        test_shadow_update();
        test_edge_duties();
        test_drain();
        test_reenable();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
